// File: rtl/tc_moore_if.sv
// Sensor and lamp bundle for the two-street traffic-light controller.
// The controller takes the slave side; the environment driving the sensors takes the master side.
interface tc_moore_if;
    logic       T_A;
    logic       T_B;
    logic [2:0] L_A;
    logic [2:0] L_B;

    modport master (output T_A, output T_B, input L_A, input L_B);
    modport slave  (input T_A, input T_B, output L_A, output L_B);
endinterface

// File: rtl/tc_moore.sv
// Moore two-street traffic-light controller: green held while its street has traffic,
// timed yellow on every hand-over. Lamps are registered decodes of the state.
module tc_moore #(
    parameter int YELLOW_CYCLES    = 1,
    parameter int MIN_GREEN_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        R,
    tc_moore_if.slave   bus
);

    typedef enum logic [1:0] {
        S0 = 2'd0,  // A green, B red
        S1 = 2'd1,  // A yellow, B red
        S2 = 2'd2,  // A red, B green
        S3 = 2'd3   // A red, B yellow
    } state_t;

    localparam logic [3:0] YEL_LAST = 4'(YELLOW_CYCLES - 1);
    localparam logic [3:0] MIN_LAST = 4'(MIN_GREEN_CYCLES - 1);
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b100;

    function automatic logic [2:0] lamp_a(input state_t s);
        logic [2:0] l;
        case (s)
            S0:      l = LAMP_G;
            S1:      l = LAMP_Y;
            default: l = LAMP_R;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] lamp_b(input state_t s);
        logic [2:0] l;
        case (s)
            S2:      l = LAMP_G;
            S3:      l = LAMP_Y;
            default: l = LAMP_R;
        endcase
        return l;
    endfunction

    // Power-up values let the block run correctly without R ever being asserted.
    state_t     state_r = S0;
    logic [3:0] cnt_r   = 4'd0;
    logic [2:0] l_a_r   = 3'b001;
    logic [2:0] l_b_r   = 3'b100;

    state_t     state_s;
    logic [3:0] cnt_s;

    // Next-state and phase-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = 4'd0;
        case (state_r)
            S0: begin
                if ((cnt_r >= MIN_LAST) && !bus.T_A) begin
                    state_s = S1;
                end else begin
                    state_s = S0;
                end
            end
            S1: begin
                if (cnt_r == YEL_LAST) begin
                    state_s = S2;
                end else begin
                    state_s = S1;
                end
            end
            S2: begin
                if ((cnt_r >= MIN_LAST) && !bus.T_B) begin
                    state_s = S3;
                end else begin
                    state_s = S2;
                end
            end
            S3: begin
                if (cnt_r == YEL_LAST) begin
                    state_s = S0;
                end else begin
                    state_s = S3;
                end
            end
            default: state_s = S0;
        endcase

        if (state_s != state_r) begin
            cnt_s = 4'd0;
        end else if (cnt_r == 4'd15) begin
            cnt_s = 4'd15;
        end else begin
            cnt_s = cnt_r + 4'd1;
        end
    end

    // State, counter and lamp registers; lamps follow the new state on the same edge.
    always_ff @(posedge CLK) begin
        if (R) begin
            state_r <= S0;
            cnt_r   <= 4'd0;
            l_a_r   <= lamp_a(S0);
            l_b_r   <= lamp_b(S0);
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            l_a_r   <= lamp_a(state_s);
            l_b_r   <= lamp_b(state_s);
        end
    end

    assign bus.L_A = l_a_r;
    assign bus.L_B = l_b_r;

endmodule

// File: tb/tb_tc_moore.sv
// Self-checking bench for tc_moore: a phase/age model checked every cycle on two
// parameterisations, plus directed literal expectations from the test plan.
module tb_tc_moore;

    logic CLK = 1'b0;
    logic R   = 1'b0;
    logic t_a = 1'b1;
    logic t_b = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    tc_moore_if if0 ();
    tc_moore_if if1 ();

    assign if0.T_A = t_a;
    assign if0.T_B = t_b;
    assign if1.T_A = t_a;
    assign if1.T_B = t_b;

    tc_moore dut0 (.CLK(CLK), .R(R), .bus(if0.slave));
    tc_moore #(.YELLOW_CYCLES(3), .MIN_GREEN_CYCLES(2)) dut1 (.CLK(CLK), .R(R), .bus(if1.slave));

    always #5 CLK = ~CLK;

    // Model: phase 0..3 = A green, A yellow, B green, B yellow; age = cycles spent in phase.
    int phase [2] = '{0, 0};
    int age   [2] = '{0, 0};
    int yel   [2] = '{1, 3};
    int ming  [2] = '{1, 2};

    function automatic logic [2:0] exp_a(input int p);
        return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] exp_b(input int p);
        return (p == 2) ? 3'b001 : (p == 3) ? 3'b010 : 3'b100;
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            bit leave;
            if (R) begin
                phase[i] = 0;
                age[i]   = 0;
            end else begin
                if (phase[i] == 0)      leave = (age[i] + 1 >= ming[i]) && !t_a;
                else if (phase[i] == 2) leave = (age[i] + 1 >= ming[i]) && !t_b;
                else                    leave = (age[i] + 1 == yel[i]);
                if (leave) begin
                    phase[i] = (phase[i] + 1) % 4;
                    age[i]   = 0;
                end else begin
                    age[i]   = age[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model and the lamp safety invariant.
    always @(negedge CLK) begin
        check("m0_LA", if0.L_A, exp_a(phase[0]));
        check("m0_LB", if0.L_B, exp_b(phase[0]));
        check("m1_LA", if1.L_A, exp_a(phase[1]));
        check("m1_LB", if1.L_B, exp_b(phase[1]));
        n_cmp++;
        if (!(if0.L_A == 3'b100 || if0.L_B == 3'b100) || !(if1.L_A == 3'b100 || if1.L_B == 3'b100)) begin
            n_bad++;
            $display("FAIL safety: dut0 %b/%b dut1 %b/%b at %0t", if0.L_A, if0.L_B, if1.L_A, if1.L_B, $time);
        end
    end

    task automatic cyc(input logic ta, input logic tb, input logic rr);
        @(negedge CLK);
        #1;
        t_a = ta;
        t_b = tb;
        R   = rr;
        @(posedge CLK);
        #1;
    endtask

    task automatic lit0(input string name, input logic [2:0] ea, input logic [2:0] eb);
        check({name, "_A"}, if0.L_A, ea);
        check({name, "_B"}, if0.L_B, eb);
    endtask

    logic [2:0] seq1_a [13] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100,
                                3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
    logic [2:0] seq1_b [13] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001,
                                3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100};
    logic [2:0] seq0_a [4]  = '{3'b001, 3'b010, 3'b100, 3'b100};
    logic [2:0] seq0_b [4]  = '{3'b100, 3'b100, 3'b001, 3'b010};

    initial begin
        #1;
        lit0("powerup", 3'b001, 3'b100);

        // Green A held while T_A=1
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            lit0("holdA", 3'b001, 3'b100);
        end

        // Hand-over A -> B
        cyc(1'b0, 1'b1, 1'b0);
        lit0("AtoB_y", 3'b010, 3'b100);
        cyc(1'b0, 1'b1, 1'b0);
        lit0("AtoB_g", 3'b100, 3'b001);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            lit0("holdB", 3'b100, 3'b001);
        end

        // Reset in the middle of B green
        cyc(1'b0, 1'b1, 1'b1);
        lit0("rst_midS2", 3'b001, 3'b100);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        lit0("backS2", 3'b100, 3'b001);

        // Hand-over B -> A
        cyc(1'b1, 1'b0, 1'b0);
        lit0("BtoA_y", 3'b100, 3'b010);
        cyc(1'b1, 1'b0, 1'b0);
        lit0("BtoA_g", 3'b001, 3'b100);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            lit0("holdA2", 3'b001, 3'b100);
        end

        // No traffic: period-4 cycling on defaults, long phases on dut1
        cyc(1'b0, 1'b0, 1'b1);
        lit0("rst_idle", 3'b001, 3'b100);
        check("p_LA0", if1.L_A, seq1_a[0]);
        check("p_LB0", if1.L_B, seq1_b[0]);
        for (int i = 1; i < 13; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check("idle_LA", if0.L_A, seq0_a[i % 4]);
            check("idle_LB", if0.L_B, seq0_b[i % 4]);
            check("p_LA", if1.L_A, seq1_a[i]);
            check("p_LB", if1.L_B, seq1_b[i]);
        end

        // Both sensors busy: current green held indefinitely
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            lit0("both_hold", 3'b001, 3'b100);
            check("both_hold1", if1.L_A, 3'b001);
        end

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
